// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable frame format.
// Rx is synchronised, sampled on a divided tick, and each bit is decided by a
// 3-sample majority vote around mid-bit. Completed frames land in a holding
// register with a valid/ack handshake and a sticky overrun flag.
module uart_rx_param #(
  parameter int BoardFreq  = 100000000,
  parameter int BaudRate   = 9600,
  parameter int Oversample = 16,
  parameter int DataBits   = 8,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1,
  parameter int DivCount   = BoardFreq / (BaudRate * Oversample)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Rx,
  input  logic                ReadEn,
  input  logic                outputAck,
  output logic [DataBits-1:0] outputByte,
  output logic                outputReady,
  output logic                parityErr,
  output logic                frameErr,
  output logic                overrun,
  output logic                busy
);

  localparam int DivW = (DivCount > 1) ? $clog2(DivCount) : 1;
  localparam int SW   = $clog2(Oversample);
  localparam int BW   = $clog2(DataBits);

  localparam logic [DivW-1:0] DivLast  = DivW'(DivCount - 1);
  localparam logic [SW-1:0]   SVote0   = SW'(Oversample / 2 - 1);
  localparam logic [SW-1:0]   SVote1   = SW'(Oversample / 2);
  localparam logic [SW-1:0]   SVote2   = SW'(Oversample / 2 + 1);
  localparam logic [SW-1:0]   SLast    = SW'(Oversample - 1);
  localparam logic [BW-1:0]   BLast    = BW'(DataBits - 1);
  localparam logic            StopLast = (StopBits == 2);
  localparam logic            OddPar   = (ParityMode == 2);
  localparam logic            HasPar   = (ParityMode != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]          r_sync;
  logic                w_rxs;
  logic [DivW-1:0]     r_div;
  logic                w_tick;
  state_t              r_state;
  state_t              w_state_next;
  logic [SW-1:0]       r_s;
  logic [BW-1:0]       r_bit_idx;
  logic                r_stop_idx;
  logic                r_v0;
  logic                r_v1;
  logic                w_vote;
  logic                w_vote_pt;
  logic                w_bit_end;
  logic                w_par_exp;
  logic [DataBits-1:0] r_shift;
  logic                r_perr_pend;
  logic                r_ferr_pend;
  logic                r_commit;
  logic [DataBits-1:0] r_byte;
  logic                r_ready;
  logic                r_perr;
  logic                r_ferr;
  logic                r_overrun;
  logic                w_busy;

  assign w_rxs = r_sync[1];

  // Two-flop synchroniser for the asynchronous Rx pin; idles high.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], Rx};
  end

  assign w_tick = (r_div == DivLast);

  // Free-running sample-tick divider, pulses w_tick on the wrap cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)        r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Majority of the two stored samples and the live sample at the third point.
  assign w_vote    = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);
  assign w_vote_pt = w_tick && (r_s == SVote2);
  assign w_bit_end = w_tick && (r_s == SLast);
  assign w_par_exp = (^r_shift) ^ OddPar;

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // FSM next-state logic; all transitions happen on a sample tick.
  always_comb begin
    w_state_next = r_state;
    if (!ReadEn) begin
      w_state_next = S_IDLE;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE:   if (!w_rxs) w_state_next = S_START;
        S_START: begin
          if (w_vote_pt && w_vote) w_state_next = S_IDLE;
          else if (w_bit_end)      w_state_next = S_DATA;
        end
        S_DATA:   if (w_bit_end && (r_bit_idx == BLast))
                    w_state_next = HasPar ? S_PARITY : S_STOP;
        S_PARITY: if (w_bit_end) w_state_next = S_STOP;
        S_STOP:   if (w_vote_pt && (r_stop_idx == StopLast))
                    w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM output logic.
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  assign busy = w_busy;

  // Frame datapath: sample counter, vote samples, shift register, pending flags.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_s         <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_v0        <= 1'b1;
      r_v1        <= 1'b1;
      r_shift     <= '0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
      r_commit    <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (!ReadEn) begin
        r_s <= '0;
      end else if (w_tick) begin
        if (r_state == S_IDLE) begin
          r_s         <= '0;
          r_bit_idx   <= '0;
          r_stop_idx  <= 1'b0;
          r_perr_pend <= 1'b0;
          r_ferr_pend <= 1'b0;
        end else begin
          r_s <= (r_s == SLast) ? '0 : r_s + 1'b1;
          if (r_s == SVote0) r_v0 <= w_rxs;
          if (r_s == SVote1) r_v1 <= w_rxs;
          case (r_state)
            S_DATA: begin
              if (w_vote_pt) r_shift   <= {w_vote, r_shift[DataBits-1:1]};
              if (w_bit_end) r_bit_idx <= r_bit_idx + 1'b1;
            end
            S_PARITY: begin
              if (w_vote_pt && (w_vote != w_par_exp)) r_perr_pend <= 1'b1;
            end
            S_STOP: begin
              if (w_vote_pt) begin
                if (!w_vote) r_ferr_pend <= 1'b1;
                if (r_stop_idx == StopLast) r_commit <= 1'b1;
              end
              if (w_bit_end) r_stop_idx <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Holding register and handshake; a commit into an unacked byte is an overrun.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_byte    <= '0;
      r_ready   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_commit && (!r_ready || outputAck)) begin
      r_byte  <= r_shift;
      r_perr  <= r_perr_pend;
      r_ferr  <= r_ferr_pend;
      r_ready <= 1'b1;
      if (outputAck && r_ready) r_overrun <= 1'b0;
    end else if (r_commit) begin
      r_overrun <= 1'b1;
    end else if (outputAck && r_ready) begin
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign outputByte  = r_byte;
  assign outputReady = r_ready;
  assign parityErr   = r_perr;
  assign frameErr    = r_ferr;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param: three instances (8N1, 8E1, 8N2)
// driven with hand-built serial frames; results checked by immediate asserts.
module tb_uart_rx_param;
  localparam int BF    = 1600000;
  localparam int BR    = 10000;
  localparam int OS    = 16;
  localparam int CLK_P = 10;
  localparam int BIT   = 160 * CLK_P;

  logic Clk = 1'b0;
  logic Rst;
  logic rx_a, rx_b, rx_c;
  logic en_a, en_b, en_c;
  logic ack_a, ack_b, ack_c;
  logic [7:0] byte_a, byte_b, byte_c;
  logic rdy_a, rdy_b, rdy_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;

  int  n_cmp = 0;
  int  n_err = 0;
  time t_rdy_a = 0;

  always #(CLK_P / 2) Clk = ~Clk;

  always @(posedge rdy_a) t_rdy_a = $time;

  uart_rx_param #(.BoardFreq(BF), .BaudRate(BR), .Oversample(OS), .DataBits(8),
                  .ParityMode(0), .StopBits(1)) u_a (
    .Clk(Clk), .Rst(Rst), .Rx(rx_a), .ReadEn(en_a), .outputAck(ack_a),
    .outputByte(byte_a), .outputReady(rdy_a), .parityErr(perr_a),
    .frameErr(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_param #(.BoardFreq(BF), .BaudRate(BR), .Oversample(OS), .DataBits(8),
                  .ParityMode(1), .StopBits(1)) u_b (
    .Clk(Clk), .Rst(Rst), .Rx(rx_b), .ReadEn(en_b), .outputAck(ack_b),
    .outputByte(byte_b), .outputReady(rdy_b), .parityErr(perr_b),
    .frameErr(ferr_b), .overrun(ovr_b), .busy(busy_b));

  uart_rx_param #(.BoardFreq(BF), .BaudRate(BR), .Oversample(OS), .DataBits(8),
                  .ParityMode(0), .StopBits(2)) u_c (
    .Clk(Clk), .Rst(Rst), .Rx(rx_c), .ReadEn(en_c), .outputAck(ack_c),
    .outputByte(byte_c), .outputReady(rdy_c), .parityErr(perr_c),
    .frameErr(ferr_c), .overrun(ovr_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic set_ack(input int sel, input logic v);
    case (sel)
      0:       ack_a = v;
      1:       ack_b = v;
      default: ack_c = v;
    endcase
  endtask

  // One-cycle ack; returns at the negedge right after the accepting posedge.
  task automatic pulse_ack(input int sel);
    @(negedge Clk);
    set_ack(sel, 1'b1);
    @(negedge Clk);
    set_ack(sel, 1'b0);
  endtask

  // Drive n line bits of fr, LSB first, one bit period each.
  task automatic send(input int sel, input logic [15:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, fr[i]);
      #(BIT);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  initial begin
    #(900000 * CLK_P);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    longint lat;
    time t0;
    Rst = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    #23;
    chk("rst_byte", byte_a, 8'h00);
    chk("rst_ready", rdy_a, 1'b0);
    chk("rst_perr", perr_a, 1'b0);
    chk("rst_ferr", ferr_a, 1'b0);
    chk("rst_overrun", ovr_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    #(BIT);

    // 1. 8N1 0xA5, latency, hold, ack
    t0 = $time;
    send(0, f8n1(8'hA5, 1'b1), 10);
    chk("t1_ready", rdy_a, 1'b1);
    chk("t1_byte", byte_a, 8'hA5);
    chk("t1_perr", perr_a, 1'b0);
    chk("t1_ferr", ferr_a, 1'b0);
    lat = longint'((t_rdy_a - t0) / CLK_P);
    $display("t1 latency %0d clk", lat);
    chk("t1_latency_window", (lat >= 1450 && lat <= 1700), 1'b1);
    repeat (200) @(negedge Clk);
    chk("t1_ready_held", rdy_a, 1'b1);
    pulse_ack(0);
    chk("t1_ready_after_ack", rdy_a, 1'b0);
    chk("t1_byte_kept", byte_a, 8'hA5);
    #(BIT);

    // 3a. stop bit low -> frame error
    send(0, f8n1(8'h3C, 1'b0), 10);
    set_rx(0, 1'b1);
    #(2 * BIT);
    chk("t3_ready", rdy_a, 1'b1);
    chk("t3_byte", byte_a, 8'h3C);
    chk("t3_ferr", ferr_a, 1'b1);
    pulse_ack(0);
    #(BIT);

    // 4a. 30-clock glitch on idle line -> false start
    set_rx(0, 1'b0);
    #(30 * CLK_P);
    set_rx(0, 1'b1);
    k = 0;
    while (!busy_a && k < 60) begin @(negedge Clk); k++; end
    chk("t4_busy_rise", busy_a, 1'b1);
    k = 0;
    while (busy_a && k < 160) begin @(negedge Clk); k++; end
    chk("t4_busy_fall", busy_a, 1'b0);
    #(BIT);
    chk("t4_no_ready", rdy_a, 1'b0);

    // 4b. one-sample glitch inside data bit 3 of 0x00
    set_rx(0, 1'b0);
    #(4 * BIT);
    #(850);
    set_rx(0, 1'b1);
    #(100);
    set_rx(0, 1'b0);
    #(BIT - 950);
    #(4 * BIT);
    set_rx(0, 1'b1);
    #(BIT);
    chk("t4_glitch_ready", rdy_a, 1'b1);
    chk("t4_glitch_byte", byte_a, 8'h00);
    pulse_ack(0);
    #(BIT);

    // 5a. back-to-back without ack -> overrun
    send(0, f8n1(8'h11, 1'b1), 10);
    send(0, f8n1(8'h22, 1'b1), 10);
    chk("t5_ready", rdy_a, 1'b1);
    chk("t5_byte_first_kept", byte_a, 8'h11);
    chk("t5_overrun", ovr_a, 1'b1);
    pulse_ack(0);
    chk("t5_overrun_cleared", ovr_a, 1'b0);
    chk("t5_ready_cleared", rdy_a, 1'b0);
    chk("t5_byte_after_ack", byte_a, 8'h11);
    #(BIT);

    // 5b. ack coincides with second commit
    send(0, f8n1(8'h11, 1'b1), 10);
    chk("t5b_first_ready", rdy_a, 1'b1);
    fork
      send(0, f8n1(8'h22, 1'b1), 10);
      begin
        k = 0;
        while (!busy_a && k < 300) begin @(negedge Clk); k++; end
        chk("t5b_busy_rise", busy_a, 1'b1);
        k = 0;
        while (busy_a && k < 2000) begin @(negedge Clk); k++; end
        chk("t5b_busy_fall", busy_a, 1'b0);
        ack_a = 1'b1;
        @(negedge Clk);
        ack_a = 1'b0;
      end
    join
    chk("t5b_byte", byte_a, 8'h22);
    chk("t5b_ready", rdy_a, 1'b1);
    chk("t5b_overrun", ovr_a, 1'b0);
    pulse_ack(0);
    chk("t5b_ready_cleared", rdy_a, 1'b0);
    #(BIT);

    // 6b. ReadEn dropped mid-frame
    fork
      send(0, f8n1(8'h33, 1'b1), 10);
      begin
        #(3 * BIT);
        chk("t6_busy_before_drop", busy_a, 1'b1);
        en_a = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("t6_busy_dropped", busy_a, 1'b0);
      end
    join
    #(BIT);
    en_a = 1'b1;
    #(BIT);
    chk("t6_no_ready", rdy_a, 1'b0);
    send(0, f8n1(8'h81, 1'b1), 10);
    chk("t6_ready_81", rdy_a, 1'b1);
    chk("t6_byte_81", byte_a, 8'h81);
    pulse_ack(0);
    #(BIT);

    // 2. even parity: 0x07 needs parity bit 1
    send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    chk("t2_ready", rdy_b, 1'b1);
    chk("t2_byte", byte_b, 8'h07);
    chk("t2_perr_bad", perr_b, 1'b1);
    chk("t2_ferr", ferr_b, 1'b0);
    pulse_ack(1);
    #(BIT);
    send(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    chk("t2_ready_good", rdy_b, 1'b1);
    chk("t2_byte_good", byte_b, 8'h07);
    chk("t2_perr_good", perr_b, 1'b0);
    pulse_ack(1);
    #(BIT);

    // 3b. two stop bits, second one low
    send(2, {5'b0, 1'b0, 1'b1, 8'hC3, 1'b0}, 11);
    set_rx(2, 1'b1);
    #(2 * BIT);
    chk("t3b_ready", rdy_c, 1'b1);
    chk("t3b_byte", byte_c, 8'hC3);
    chk("t3b_ferr", ferr_c, 1'b1);
    pulse_ack(2);
    #(BIT);
    send(2, {5'b0, 1'b1, 1'b1, 8'h3E, 1'b0}, 11);
    chk("t3b_ready_good", rdy_c, 1'b1);
    chk("t3b_byte_good", byte_c, 8'h3E);
    chk("t3b_ferr_good", ferr_c, 1'b0);
    pulse_ack(2);
    #(BIT);

    // 6a. asynchronous reset mid-data with a byte held
    send(0, f8n1(8'h96, 1'b1), 10);
    chk("t6r_held_ready", rdy_a, 1'b1);
    chk("t6r_held_byte", byte_a, 8'h96);
    fork
      send(0, f8n1(8'h5A, 1'b1), 10);
      begin
        #(4 * BIT + BIT / 2);
        chk("t6r_busy_before", busy_a, 1'b1);
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        en_a = 1'b0;
        #1;
        chk("t6r_byte", byte_a, 8'h00);
        chk("t6r_ready", rdy_a, 1'b0);
        chk("t6r_busy", busy_a, 1'b0);
        chk("t6r_overrun", ovr_a, 1'b0);
        chk("t6r_perr", perr_a, 1'b0);
        chk("t6r_ferr", ferr_a, 1'b0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
      end
    join
    #(BIT);
    en_a = 1'b1;
    #(BIT);
    chk("t6r_no_commit", rdy_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
